pc_gen_param: RTL and testbench
===============================

Name: pc_gen_param

Overview:
Parametrised next-generation PC generator for the fetch front end. It selects the next fetch address from these sources, in priority order: exception vector, EX-stage conditional-branch mispredict, ID-stage unconditional-jump mispredict, branch-predictor target, sequential increment. Unlike the current generator, it does not lose a redirect that arrives while the PC is stalled: the redirect is held in a pending register and applied on release. It also adds exception vectoring, multi-instruction fetch increment, target alignment checking and a redirect counter. It sits between the branch predictor / controller and the IF stage.

Parameters:
ADDR_W, 32, PC / target width in bits (>= 8)
RESET_PC, 32'h0000_0000, PC value loaded during reset
FETCH_INSNS, 1, instructions per fetch; sequential increment = FETCH_INSNS*4 bytes (power of two, 1..4)
EXC_BASE, 32'h0000_0080, exception vector base
EXC_CODE_W, 4, width of exception cause code
VEC_SHIFT, 2, vector stride = 1<<VEC_SHIFT bytes per cause
CNT_W, 16, redirect counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_pc  in  1  hold PC (controller)
jump_taken_predict  in  1  predictor says taken
jump_target_predict  in  ADDR_W-2  predicted target, word address [ADDR_W-1:2]
id_advance  in  1  ID→EX pipeline advance; captures cond target
cond_jump_addr_id  in  ADDR_W  conditional target computed in ID
pc_plus_1_id_r  in  ADDR_W  fall-through address of branch now in EX
cond_jump_predict_fail_ex  in  1  EX mispredict
cond_jump_taken_ex  in  1  actual EX branch outcome
uncond_jump_predict_fail_id  in  1  ID jump mispredict
uncond_jump_addr_id  in  ADDR_W  ID jump target
exc_req  in  1  exception redirect request
exc_code  in  EXC_CODE_W  exception cause
pc  out  ADDR_W  current fetch PC
pc_plus_fetch  out  ADDR_W  pc + FETCH_INSNS*4 (combinational from pc)
pc_valid  out  1  fetch PC is valid
redirect_pending  out  1  a redirect is latched awaiting stall release
misalign_err  out  1  one-cycle pulse: applied redirect target had bits[1:0]!=0
redirect_cnt  out  CNT_W  saturating count of applied redirects

Behaviour:
- Reset (rst=1 at clk edge): pc=RESET_PC, state=RUN, pc_valid=0, redirect_pending=0, misalign_err=0, redirect_cnt=0, cond_addr_ex=0, pend_addr=0, pend_pri=NONE. pc_valid goes 1 on the first edge with rst=0. A reset mid-PEND discards the pending redirect.
- cond_addr_ex register: loads cond_jump_addr_id on any edge with id_advance=1; otherwise holds.
- Redirect candidates, highest priority first:
  - EXC: EXC_BASE + (exc_code<<VEC_SHIFT).
  - EX: cond_jump_taken_ex ? cond_addr_ex : pc_plus_1_id_r.
  - ID: uncond_jump_addr_id.
  - Non-redirect sources: PRED {jump_target_predict,2'b00}, SEQ pc+FETCH_INSNS*4 (mod 2^ADDR_W, wraps silently).
- Alignment: every applied redirect target has bits[1:0] forced to 00. misalign_err=1 for one cycle if the original target bits were nonzero.
- State RUN:
  - exc_req=1: pc←EXC vector regardless of stall_pc.
  - else stall_pc=0: pc←highest-priority candidate.
  - else stall_pc=1 with EX or ID redirect active: pend_addr/pend_pri←winner, state→PEND, pc holds.
  - else stall_pc=1: pc holds.
- State PEND:
  - redirect_pending=1 and pc_valid=0; predictor and SEQ are ignored.
  - A new EX/ID redirect overwrites pending iff its priority >= pend_pri.
  - exc_req=1: pc←EXC vector, pending cleared, →RUN.
  - stall_pc=0: pc←(incoming redirect if priority > pend_pri, else pend_addr), pend_pri←NONE, →RUN.
- redirect_cnt: +1 on every edge where an EXC/EX/ID redirect is applied to pc (not when latched). Saturates at all-ones.
- Simultaneous events: EXC beats everything. EX beats ID. A redirect in the same cycle as a prediction suppresses the prediction.

Decomposition:
- Package pc_gen_pkg holds:
  - priority encoding PRI_NONE=0, PRI_ID=1, PRI_EX=2, PRI_EXC=3 (2-bit)
  - state encoding ST_RUN=0, ST_PEND=1
  - function for aligned target + misalign flag
- One natural sub-module: pc_redirect_arb. It is purely combinational and takes candidates + valids, returning winner address and priority. The top level holds the FSM, pending register, cond_addr_ex, pc and counter.

Test Plan:
- Reset release, no stall, no predict, FETCH_INSNS=1 → pc 0x0,0x4,0x8; pc_valid 0 then 1 the edge after reset drops.
- pc=0x10, jump_taken_predict with target word 0x40 → next pc=0x100. Same cycle uncond_jump_predict_fail_id to 0x200 → pc=0x200, redirect_cnt=1.
- stall_pc=1, cond_jump_predict_fail_ex, taken, captured target 0x300 → pc holds and redirect_pending=1. Next cycle ID redirect 0x500 is ignored (lower priority). Stall release → pc=0x300, redirect_pending=0.
- Stalled in PEND with ID 0x500, then EX not-taken with pc_plus_1_id_r=0x124 → pending overwritten. Release → pc=0x124.
- exc_req with exc_code=3 while stall_pc=1 in PEND → pc=0x8C the next edge (EXC_BASE 0x80, VEC_SHIFT 2), pending cleared.
- ID target 0x203 → pc=0x200 and misalign_err pulses one cycle. CNT_W=2 after 5 redirects → redirect_cnt=3.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared priority/state encodings and target alignment helpers for pc_gen_param.
package pc_gen_pkg;
  typedef enum logic [1:0] {PRI_NONE = 2'd0, PRI_ID = 2'd1, PRI_EX = 2'd2, PRI_EXC = 2'd3} pri_t;
  typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] align_tgt(input logic [MAX_W-1:0] t);
    return {t[MAX_W-1:2], 2'b00};
  endfunction
  function automatic logic misaligned(input logic [1:0] lo);
    return |lo;
  endfunction
endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: fixed-priority pick among exception, EX and ID redirect candidates.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              exc_v,
  input  logic [ADDR_W-1:0] exc_a,
  input  logic              ex_v,
  input  logic [ADDR_W-1:0] ex_a,
  input  logic              id_v,
  input  logic [ADDR_W-1:0] id_a,
  output logic [ADDR_W-1:0] win_a,
  output pri_t              win_pri
);
  always_comb begin
    win_pri = exc_v ? PRI_EXC : ex_v ? PRI_EX : id_v ? PRI_ID : PRI_NONE;
    win_a   = exc_v ? exc_a : ex_v ? ex_a : id_a;
  end
endmodule

// File: rtl/pc_gen_param.sv
// pc_gen_param: next fetch PC selection with stall-safe pending redirects, exception vectoring and redirect counting.
module pc_gen_param
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FETCH_INSNS = 1,
  parameter logic [31:0] EXC_BASE    = 32'h0000_0080,
  parameter int          EXC_CODE_W  = 4,
  parameter int          VEC_SHIFT   = 2,
  parameter int          CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_pc,
  input  logic                  jump_taken_predict,
  input  logic [ADDR_W-3:0]     jump_target_predict,
  input  logic                  id_advance,
  input  logic [ADDR_W-1:0]     cond_jump_addr_id,
  input  logic [ADDR_W-1:0]     pc_plus_1_id_r,
  input  logic                  cond_jump_predict_fail_ex,
  input  logic                  cond_jump_taken_ex,
  input  logic                  uncond_jump_predict_fail_id,
  input  logic [ADDR_W-1:0]     uncond_jump_addr_id,
  input  logic                  exc_req,
  input  logic [EXC_CODE_W-1:0] exc_code,
  output logic [ADDR_W-1:0]     pc,
  output logic [ADDR_W-1:0]     pc_plus_fetch,
  output logic                  pc_valid,
  output logic                  redirect_pending,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      redirect_cnt
);
  state_t state, state_n;
  pri_t pend_pri, pend_pri_n, win_pri;
  logic [ADDR_W-1:0] cond_addr_ex, pend_addr, pend_addr_n, pc_n, exc_a, ex_a, win_a, raw;
  logic apply, valid_r;
  assign exc_a = ADDR_W'(EXC_BASE) + (ADDR_W'(exc_code) << VEC_SHIFT);
  assign ex_a = cond_jump_taken_ex ? cond_addr_ex : pc_plus_1_id_r;
  assign pc_plus_fetch = pc + ADDR_W'(FETCH_INSNS * 4);
  assign pc_valid = valid_r && state == ST_RUN;
  assign redirect_pending = state == ST_PEND;
  pc_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .exc_v  (exc_req),
    .exc_a  (exc_a),
    .ex_v   (cond_jump_predict_fail_ex),
    .ex_a   (ex_a),
    .id_v   (uncond_jump_predict_fail_id),
    .id_a   (uncond_jump_addr_id),
    .win_a  (win_a),
    .win_pri(win_pri)
  );
  // Pending targets are kept unaligned so the misalign pulse fires when they are applied.
  always_comb begin
    state_n = state;
    pend_addr_n = pend_addr;
    pend_pri_n = pend_pri;
    apply = 1'b0;
    raw = win_a;
    pc_n = pc;
    if (exc_req) begin
      apply = 1'b1;
      pend_pri_n = PRI_NONE;
      state_n = ST_RUN;
    end else if (state == ST_RUN) begin
      if (!stall_pc) begin
        apply = win_pri != PRI_NONE;
        pc_n = jump_taken_predict ? {jump_target_predict, 2'b00} : pc_plus_fetch;
      end else if (win_pri != PRI_NONE) begin
        pend_addr_n = win_a;
        pend_pri_n = win_pri;
        state_n = ST_PEND;
      end
    end else if (!stall_pc) begin
      apply = 1'b1;
      raw = win_pri > pend_pri ? win_a : pend_addr;
      pend_pri_n = PRI_NONE;
      state_n = ST_RUN;
    end else if (win_pri != PRI_NONE && win_pri >= pend_pri) begin
      pend_addr_n = win_a;
      pend_pri_n = win_pri;
    end
    if (apply) pc_n = ADDR_W'(align_tgt(MAX_W'(raw)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pc <= ADDR_W'(RESET_PC);
      valid_r <= 1'b0;
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
      cond_addr_ex <= '0;
      pend_addr <= '0;
      pend_pri <= PRI_NONE;
    end else begin
      state <= state_n;
      pc <= pc_n;
      valid_r <= 1'b1;
      misalign_err <= apply && misaligned(raw[1:0]);
      if (apply && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (id_advance) cond_addr_ex <= cond_jump_addr_id;
      pend_addr <= pend_addr_n;
      pend_pri <= pend_pri_n;
    end
  end
endmodule

// File: tb/tb_pc_gen_param.sv
// tb_pc_gen_param: directed vector table plus hand sequences for pending, exception, reset and saturation cases.
module tb_pc_gen_param;
  typedef struct packed {
    logic        stall;
    logic        pred;
    logic [29:0] tgt;
    logic        id;
    logic [31:0] ida;
    logic        ex;
    logic        tk;
    logic [31:0] pc1;
    logic        adv;
    logic [31:0] cid;
    logic        exc;
    logic [3:0]  code;
  } vec_t;
  typedef struct packed {
    vec_t        i;
    logic [31:0] pc;
    logic        pend;
    logic        mis;
    logic [15:0] cnt;
  } rec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic stall_pc, jump_taken_predict, id_advance, cond_jump_predict_fail_ex, cond_jump_taken_ex;
  logic uncond_jump_predict_fail_id, exc_req;
  logic [29:0] jump_target_predict;
  logic [31:0] cond_jump_addr_id, pc_plus_1_id_r, uncond_jump_addr_id;
  logic [3:0] exc_code;
  logic [31:0] pc, pc_plus_fetch, pc2, pc_plus_fetch2;
  logic pc_valid, redirect_pending, misalign_err, pc_valid2, redirect_pending2, misalign_err2;
  logic [15:0] redirect_cnt;
  logic [1:0] redirect_cnt2;
  int n_cmp = 0, n_bad = 0;
  rec_t tbl[12];

  always #5 clk = ~clk;

  pc_gen_param dut (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .jump_taken_predict(jump_taken_predict),
    .jump_target_predict(jump_target_predict), .id_advance(id_advance),
    .cond_jump_addr_id(cond_jump_addr_id), .pc_plus_1_id_r(pc_plus_1_id_r),
    .cond_jump_predict_fail_ex(cond_jump_predict_fail_ex), .cond_jump_taken_ex(cond_jump_taken_ex),
    .uncond_jump_predict_fail_id(uncond_jump_predict_fail_id), .uncond_jump_addr_id(uncond_jump_addr_id),
    .exc_req(exc_req), .exc_code(exc_code), .pc(pc), .pc_plus_fetch(pc_plus_fetch),
    .pc_valid(pc_valid), .redirect_pending(redirect_pending), .misalign_err(misalign_err),
    .redirect_cnt(redirect_cnt)
  );

  pc_gen_param #(.FETCH_INSNS(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall_pc(stall_pc), .jump_taken_predict(jump_taken_predict),
    .jump_target_predict(jump_target_predict), .id_advance(id_advance),
    .cond_jump_addr_id(cond_jump_addr_id), .pc_plus_1_id_r(pc_plus_1_id_r),
    .cond_jump_predict_fail_ex(cond_jump_predict_fail_ex), .cond_jump_taken_ex(cond_jump_taken_ex),
    .uncond_jump_predict_fail_id(uncond_jump_predict_fail_id), .uncond_jump_addr_id(uncond_jump_addr_id),
    .exc_req(exc_req), .exc_code(exc_code), .pc(pc2), .pc_plus_fetch(pc_plus_fetch2),
    .pc_valid(pc_valid2), .redirect_pending(redirect_pending2), .misalign_err(misalign_err2),
    .redirect_cnt(redirect_cnt2)
  );

  function automatic vec_t iv(logic stall, logic pred, logic [29:0] tgt, logic id, logic [31:0] ida,
                              logic ex, logic tk, logic [31:0] pc1, logic adv, logic [31:0] cid,
                              logic exc, logic [3:0] code);
    return '{stall, pred, tgt, id, ida, ex, tk, pc1, adv, cid, exc, code};
  endfunction

  task automatic drive(input vec_t v);
    stall_pc = v.stall; jump_taken_predict = v.pred; jump_target_predict = v.tgt;
    uncond_jump_predict_fail_id = v.id; uncond_jump_addr_id = v.ida;
    cond_jump_predict_fail_ex = v.ex; cond_jump_taken_ex = v.tk; pc_plus_1_id_r = v.pc1;
    id_advance = v.adv; cond_jump_addr_id = v.cid; exc_req = v.exc; exc_code = v.code;
  endtask

  task automatic step(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [31:0] p, input logic pe, input logic mi, input logic [15:0] c);
    chk({nm, " pc"}, 64'(pc), 64'(p));
    chk({nm, " pending"}, 64'(redirect_pending), 64'(pe));
    chk({nm, " misalign"}, 64'(misalign_err), 64'(mi));
    chk({nm, " cnt"}, 64'(redirect_cnt), 64'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z, v;
    z = '0;
    tbl[0]  = '{iv(0,0,0,     1,'h10, 0,0,0,     0,0,     0,0), 32'h10,  1'b0, 1'b0, 16'd1};
    tbl[1]  = '{iv(0,1,'h40,  0,0,    0,0,0,     0,0,     0,0), 32'h100, 1'b0, 1'b0, 16'd1};
    tbl[2]  = '{iv(0,1,'h40,  1,'h200,0,0,0,     0,0,     0,0), 32'h200, 1'b0, 1'b0, 16'd2};
    tbl[3]  = '{iv(0,0,0,     0,0,    0,0,0,     0,0,     0,0), 32'h204, 1'b0, 1'b0, 16'd2};
    tbl[4]  = '{iv(1,0,0,     0,0,    0,0,0,     0,0,     0,0), 32'h204, 1'b0, 1'b0, 16'd2};
    tbl[5]  = '{iv(1,1,'h40,  0,0,    0,0,0,     0,0,     0,0), 32'h204, 1'b0, 1'b0, 16'd2};
    tbl[6]  = '{iv(0,0,0,     1,'h203,0,0,0,     0,0,     0,0), 32'h200, 1'b0, 1'b1, 16'd3};
    tbl[7]  = '{iv(0,0,0,     0,0,    0,0,0,     0,0,     0,0), 32'h204, 1'b0, 1'b0, 16'd3};
    tbl[8]  = '{iv(0,0,0,     1,'h500,1,0,'h124, 0,0,     0,0), 32'h124, 1'b0, 1'b0, 16'd4};
    tbl[9]  = '{iv(1,0,0,     1,'h500,0,0,0,     0,0,     1,3), 32'h8C,  1'b0, 1'b0, 16'd5};
    tbl[10] = '{iv(0,0,0,     0,0,    0,0,0,     1,'h300, 0,0), 32'h90,  1'b0, 1'b0, 16'd5};
    tbl[11] = '{iv(0,0,0,     0,0,    1,1,'h124, 0,0,     0,0), 32'h300, 1'b0, 1'b0, 16'd6};
    drive(z);
    repeat (2) @(posedge clk);
    #1;
    chk4("reset", 32'h0, 1'b0, 1'b0, 16'd0);
    chk("reset valid", 64'(pc_valid), 64'(0));
    chk("reset pc_plus_fetch", 64'(pc_plus_fetch), 64'h4);
    chk("reset pc_plus_fetch x2", 64'(pc_plus_fetch2), 64'h8);
    rst = 1'b0;
    step(z);
    chk("seq1 pc", 64'(pc), 64'h4);
    chk("seq1 valid", 64'(pc_valid), 64'(1));
    chk("seq1 pc x2", 64'(pc2), 64'h8);
    step(z);
    chk("seq2 pc", 64'(pc), 64'h8);
    chk("seq2 pc x2", 64'(pc2), 64'h10);
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].i);
      chk4($sformatf("v%0d", k), tbl[k].pc, tbl[k].pend, tbl[k].mis, tbl[k].cnt);
    end
    step(z);
    chk4("A0", 32'h304, 1'b0, 1'b0, 16'd6);
    v = z; v.stall = 1; v.ex = 1; v.tk = 1; step(v);
    chk4("A latch ex", 32'h304, 1'b1, 1'b0, 16'd6);
    chk("A valid low", 64'(pc_valid), 64'(0));
    v = z; v.stall = 1; v.id = 1; v.ida = 'h500; step(v);
    chk4("A id ignored", 32'h304, 1'b1, 1'b0, 16'd6);
    step(z);
    chk4("A release", 32'h300, 1'b0, 1'b0, 16'd7);
    chk("A valid high", 64'(pc_valid), 64'(1));
    v = z; v.stall = 1; v.id = 1; v.ida = 'h500; step(v);
    chk4("B latch id", 32'h300, 1'b1, 1'b0, 16'd7);
    v = z; v.stall = 1; v.ex = 1; v.pc1 = 'h124; step(v);
    chk4("B ex overwrite", 32'h300, 1'b1, 1'b0, 16'd7);
    step(z);
    chk4("B release", 32'h124, 1'b0, 1'b0, 16'd8);
    v = z; v.stall = 1; v.id = 1; v.ida = 'h500; step(v);
    chk4("C latch id", 32'h124, 1'b1, 1'b0, 16'd8);
    v = z; v.stall = 1; v.exc = 1; v.code = 3; step(v);
    chk4("C exc", 32'h8C, 1'b0, 1'b0, 16'd9);
    step(z);
    chk4("C after", 32'h90, 1'b0, 1'b0, 16'd9);
    v = z; v.stall = 1; v.id = 1; v.ida = 'h500; step(v);
    chk4("D latch id", 32'h90, 1'b1, 1'b0, 16'd9);
    v = z; v.ex = 1; v.tk = 1; step(v);
    chk4("D release ex wins", 32'h300, 1'b0, 1'b0, 16'd10);
    v = z; v.stall = 1; v.id = 1; v.ida = 'h503; step(v);
    chk4("D2 latch odd", 32'h300, 1'b1, 1'b0, 16'd10);
    step(z);
    chk4("D2 release", 32'h500, 1'b0, 1'b1, 16'd11);
    step(z);
    chk4("D2 pulse end", 32'h504, 1'b0, 1'b0, 16'd11);
    v = z; v.stall = 1; v.id = 1; v.ida = 'h600; step(v);
    chk4("E latch", 32'h504, 1'b1, 1'b0, 16'd11);
    rst = 1'b1;
    step(z);
    chk4("E reset", 32'h0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    step(z);
    chk4("E after", 32'h4, 1'b0, 1'b0, 16'd0);
    chk("E valid", 64'(pc_valid), 64'(1));
    for (int k = 0; k < 4; k++) begin
      v = z; v.id = 1; v.ida = 32'h40 * (k + 1); step(v);
      if (k == 2) chk("F cnt x2 at 3", 64'(redirect_cnt2), 64'd3);
    end
    v = z; v.id = 1; v.ida = 32'hFFFF_FFFC; step(v);
    chk4("F wrap tgt", 32'hFFFF_FFFC, 1'b0, 1'b0, 16'd5);
    chk("F cnt x2 sat", 64'(redirect_cnt2), 64'd3);
    step(z);
    chk("F wrap pc", 64'(pc), 64'h0);
    chk("F wrap pc x2", 64'(pc2), 64'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
